// File: rtl/batalha_pkg.sv
// Shared definitions for the Batalha Naval placement logic: ship codes, sizes,
// the hidroaviao offset table and the validator FSM states.
package batalha_pkg;

  localparam logic [2:0] TIPO_SUBMARINO    = 3'd0;
  localparam logic [2:0] TIPO_CRUZADOR     = 3'd1;
  localparam logic [2:0] TIPO_HIDROAVIAO   = 3'd2;
  localparam logic [2:0] TIPO_ENCOURACADO  = 3'd3;
  localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd4;

  localparam int MAX_PIECES = 5;

  // Hidroaviao offsets, one row per orientacao; piece k lives in bits [2k+1:2k].
  localparam logic [3:0][9:0] HIDRO_DX = {
    {4'b0, 2'd1, 2'd0, 2'd1},
    {4'b0, 2'd0, 2'd1, 2'd0},
    {4'b0, 2'd2, 2'd1, 2'd0},
    {4'b0, 2'd2, 2'd1, 2'd0}
  };
  localparam logic [3:0][9:0] HIDRO_DY = {
    {4'b0, 2'd2, 2'd1, 2'd0},
    {4'b0, 2'd2, 2'd1, 2'd0},
    {4'b0, 2'd1, 2'd0, 2'd1},
    {4'b0, 2'd0, 2'd1, 2'd0}
  };

  typedef enum logic [2:0] {IDLE, BUILD, SCAN, DRAIN, WRITE, DONE} state_t;

  // Invalid codes report size 0, which the mask generator treats as a border hit.
  function automatic logic [2:0] ship_size(input logic [2:0] tipo);
    case (tipo)
      TIPO_SUBMARINO:    return 3'd1;
      TIPO_CRUZADOR:     return 3'd2;
      TIPO_HIDROAVIAO:   return 3'd3;
      TIPO_ENCOURACADO:  return 3'd4;
      TIPO_PORTA_AVIOES: return 3'd5;
      default:           return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ship_mask_gen.sv
// Combinational occupancy-mask builder: turns a placement request into a
// BOARD_DIM x BOARD_DIM bit mask (bit = y*BOARD_DIM + x) plus a border flag.
module ship_mask_gen
  import batalha_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int COORD_W   = 4
) (
  input  logic [2:0]                       tipo,
  input  logic                             direcao,
  input  logic [1:0]                       orientacao,
  input  logic [COORD_W-1:0]               x1,
  input  logic [COORD_W-1:0]               y1,
  output logic [BOARD_DIM*BOARD_DIM-1:0]   mask,
  output logic                             borda
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int XW    = COORD_W + 1;
  localparam logic [XW-1:0] DIM = XW'(BOARD_DIM);

  logic [2:0]            size;
  logic [MAX_PIECES-1:0] occ;
  logic [XW-1:0]         cx [MAX_PIECES];
  logic [XW-1:0]         cy [MAX_PIECES];

  // One extra coordinate bit so an origin near the edge cannot wrap back on.
  always_comb begin
    size  = ship_size(tipo);
    borda = (size == 3'd0);
    for (int k = 0; k < MAX_PIECES; k++) begin
      occ[k] = (3'(k) < size);
      if (tipo == TIPO_HIDROAVIAO) begin
        cx[k] = {1'b0, x1} + XW'(HIDRO_DX[orientacao][2*k +: 2]);
        cy[k] = {1'b0, y1} + XW'(HIDRO_DY[orientacao][2*k +: 2]);
      end else begin
        cx[k] = {1'b0, x1} + (direcao ? XW'(0) : XW'(k));
        cy[k] = {1'b0, y1} + (direcao ? XW'(k) : XW'(0));
      end
      if (occ[k] && ((cx[k] >= DIM) || (cy[k] >= DIM)))
        borda = 1'b1;
    end
  end

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    logic [MAX_PIECES-1:0] hit;
    for (genvar gk = 0; gk < MAX_PIECES; gk++) begin : g_piece
      assign hit[gk] = occ[gk] && (cx[gk] == XW'(gi % BOARD_DIM))
                               && (cy[gk] == XW'(gi / BOARD_DIM));
    end
    assign mask[gi] = |hit;
  end

endmodule

// File: rtl/validador_param.sv
// Ship-placement validator: checks a request against the border and the
// player's stored ships, then appends it. VALIDADOR_ADJACENCY_EN also forbids touching ships.
module validador_param
  import batalha_pkg::*;
#(
  parameter int BOARD_DIM   = 8,
  parameter int MAX_SHIPS   = 11,
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 4,
  parameter int ADDR_W      = 5,
  parameter int PLAYER_W    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           novo_jogo,
  input  logic                           enable,
  input  logic [PLAYER_W-1:0]            jogador,
  input  logic [2:0]                     tipo,
  input  logic                           direcao,
  input  logic [1:0]                     orientacao,
  input  logic [COORD_W-1:0]             x1,
  input  logic [COORD_W-1:0]             y1,
  input  logic [BOARD_DIM*BOARD_DIM-1:0] vetor_leitura,
  output logic                           ready,
  output logic                           conflito,
  output logic                           conflitoBorda_out,
  output logic                           conflitoMemoria_out,
  output logic                           conflitoCheio_out,
  output logic                           wr_en,
  output logic [PLAYER_W-1:0]            wr_jogador,
  output logic [ADDR_W-1:0]              addr,
  output logic [BOARD_DIM*BOARD_DIM-1:0] vetor
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SHIPS);

  state_t               state_reg;
  logic [2:0]           tipo_reg;
  logic                 direcao_reg;
  logic [1:0]           orient_reg;
  logic [COORD_W-1:0]   x1_reg, y1_reg;
  logic [CELLS-1:0]     mask_reg, cmp_reg, vetor_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        count_reg [NUM_PLAYERS];
  logic [ADDR_W-1:0]    addr_reg;
  logic [PLAYER_W-1:0]  jogador_reg;
  logic                 ready_reg, wr_en_reg;
  logic                 borda_reg, memoria_reg, cheio_reg;

  logic [CELLS-1:0]     mask_w, cmp_w;
  logic                 borda_w, hit_w;

  ship_mask_gen #(.BOARD_DIM(BOARD_DIM), .COORD_W(COORD_W)) u_mask (
    .tipo       (tipo_reg),
    .direcao    (direcao_reg),
    .orientacao (orient_reg),
    .x1         (x1_reg),
    .y1         (y1_reg),
    .mask       (mask_w),
    .borda      (borda_w)
  );

`ifdef VALIDADOR_ADJACENCY_EN
  // Cells whose 3x3 neighbourhood (clipped to the board) contains cell c.
  function automatic logic [CELLS-1:0] neighbourhood(input int c);
    logic [CELLS-1:0] nb;
    int nx, ny;
    nb = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        nx = (c % BOARD_DIM) + dx;
        ny = (c / BOARD_DIM) + dy;
        if (nx >= 0 && nx < BOARD_DIM && ny >= 0 && ny < BOARD_DIM)
          nb[ny*BOARD_DIM + nx] = 1'b1;
      end
    return nb;
  endfunction

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_dilate
    localparam logic [CELLS-1:0] NB = neighbourhood(gi);
    assign cmp_w[gi] = |(mask_w & NB);
  end
`else
  assign cmp_w = mask_w;
`endif

  assign hit_w = |(vetor_leitura & cmp_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tipo_reg    <= '0;
      direcao_reg <= 1'b0;
      orient_reg  <= '0;
      x1_reg      <= '0;
      y1_reg      <= '0;
      mask_reg    <= '0;
      cmp_reg     <= '0;
      vetor_reg   <= '0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      jogador_reg <= '0;
      ready_reg   <= 1'b0;
      wr_en_reg   <= 1'b0;
      borda_reg   <= 1'b0;
      memoria_reg <= 1'b0;
      cheio_reg   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) count_reg[i] <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (novo_jogo)
            for (int i = 0; i < NUM_PLAYERS; i++) count_reg[i] <= '0;
          if (enable && !ready_reg) begin
            tipo_reg    <= tipo;
            direcao_reg <= direcao;
            orient_reg  <= orientacao;
            x1_reg      <= x1;
            y1_reg      <= y1;
            jogador_reg <= jogador;
            state_reg   <= BUILD;
          end
        end
        BUILD: begin
          mask_reg <= mask_w;
          cmp_reg  <= cmp_w;
          cnt_reg  <= count_reg[jogador_reg];
          addr_reg <= '0;
          if (borda_w) begin
            borda_reg <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= DONE;
          end else if (count_reg[jogador_reg] == MAX_CNT) begin
            cheio_reg <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= DONE;
          end else if (count_reg[jogador_reg] == '0) begin
            wr_en_reg <= 1'b1;
            vetor_reg <= mask_w;
            state_reg <= WRITE;
          end else begin
            state_reg <= SCAN;
          end
        end
        // Read data lags addr by one cycle, so slot addr_reg-1 is checked here.
        SCAN: begin
          if (addr_reg != '0 && hit_w) begin
            memoria_reg <= 1'b1;
            ready_reg   <= 1'b1;
            state_reg   <= DONE;
          end else if ({1'b0, addr_reg} == cnt_reg - CW'(1)) begin
            state_reg <= DRAIN;
          end else begin
            addr_reg <= addr_reg + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (hit_w) begin
            memoria_reg <= 1'b1;
            ready_reg   <= 1'b1;
            state_reg   <= DONE;
          end else begin
            wr_en_reg <= 1'b1;
            addr_reg  <= cnt_reg[ADDR_W-1:0];
            vetor_reg <= mask_reg;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          count_reg[jogador_reg] <= cnt_reg + CW'(1);
          ready_reg <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (!enable) begin
            ready_reg   <= 1'b0;
            borda_reg   <= 1'b0;
            memoria_reg <= 1'b0;
            cheio_reg   <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready               = ready_reg;
  assign conflitoBorda_out   = borda_reg;
  assign conflitoMemoria_out = memoria_reg;
  assign conflitoCheio_out   = cheio_reg;
  assign conflito            = borda_reg | memoria_reg | cheio_reg;
  assign wr_en               = wr_en_reg;
  assign wr_jogador          = jogador_reg;
  assign addr                = addr_reg;
  assign vetor               = vetor_reg;

endmodule

// File: tb/tb_validador_param.sv
// Bench for validador_param: directed and random placements against a
// cell-list reference model, with a behavioural per-player ship RAM.
module tb_validador_param;

  logic        clk = 1'b0;
  logic        rst, novo_jogo, enable, direcao;
  logic [0:0]  jogador;
  logic [2:0]  tipo;
  logic [1:0]  orientacao;
  logic [3:0]  x1, y1;
  logic [63:0] vetor_leitura;
  logic        ready, conflito, c_borda, c_mem, c_cheio, wr_en;
  logic [0:0]  wr_jogador;
  logic [4:0]  addr;
  logic [63:0] vetor;

  always #5 clk = ~clk;

  validador_param dut (
    .clk(clk), .rst(rst), .novo_jogo(novo_jogo), .enable(enable),
    .jogador(jogador), .tipo(tipo), .direcao(direcao), .orientacao(orientacao),
    .x1(x1), .y1(y1), .vetor_leitura(vetor_leitura),
    .ready(ready), .conflito(conflito), .conflitoBorda_out(c_borda),
    .conflitoMemoria_out(c_mem), .conflitoCheio_out(c_cheio),
    .wr_en(wr_en), .wr_jogador(wr_jogador), .addr(addr), .vetor(vetor)
  );

  // Per-player ship RAM with registered read.
  logic [63:0] ram [2][32];
  initial begin
    vetor_leitura = '0;
    for (int p = 0; p < 2; p++) for (int s = 0; s < 32; s++) ram[p][s] = '0;
  end
  always @(posedge clk) begin
    if (wr_en) ram[wr_jogador][addr] <= vetor;
    vetor_leitura <= ram[wr_jogador][addr];
  end

  int          wr_total = 0;
  logic [4:0]  wr_addr_seen;
  logic [63:0] wr_vec_seen;
  logic [0:0]  wr_pl_seen;
  always @(negedge clk) if (wr_en === 1'b1) begin
    wr_total     <= wr_total + 1;
    wr_addr_seen <= addr;
    wr_vec_seen  <= vetor;
    wr_pl_seen   <= wr_jogador;
  end

  int tests = 0, fails = 0;
  int sz [8] = '{1, 2, 3, 4, 5, 0, 0, 0};
  int hx [4][3] = '{'{0, 1, 2}, '{0, 1, 2}, '{0, 1, 0}, '{1, 0, 1}};
  int hy [4][3] = '{'{0, 1, 0}, '{1, 0, 1}, '{0, 1, 2}, '{0, 1, 2}};
  logic [63:0] model_q [2][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_place(input int t, d, o, x, y,
                                    output logic [63:0] m, output bit border);
    int cx, cy;
    m = '0;
    border = (t > 4);
    for (int k = 0; k < sz[t]; k++) begin
      if (t == 2) begin cx = x + hx[o][k]; cy = y + hy[o][k]; end
      else if (d != 0) begin cx = x; cy = y + k; end
      else begin cx = x + k; cy = y; end
      if (cx >= 8 || cy >= 8) border = 1;
      else m[cy*8 + cx] = 1'b1;
    end
  endfunction

  function automatic logic [63:0] grow(input logic [63:0] m);
    logic [63:0] g = '0;
    for (int c = 0; c < 64; c++)
      if (m[c])
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (c%8 + dx >= 0 && c%8 + dx < 8 && c/8 + dy >= 0 && c/8 + dy < 8)
              g[(c/8 + dy)*8 + c%8 + dx] = 1'b1;
    return g;
  endfunction

  task automatic do_req(input int p, t, d, o, x, y, input bit ng, input string name);
    logic [63:0] em, cm;
    bit eb, ef, emem, acc, got;
    int ea, elat, n, base;
    if (ng) begin model_q[0].delete(); model_q[1].delete(); end
    ref_place(t, d, o, x, y, em, eb);
    ef = !eb && (model_q[p].size() == 11);
    cm = em;
`ifdef VALIDADOR_ADJACENCY_EN
    cm = grow(em);
`endif
    emem = 0;
    if (!eb && !ef)
      foreach (model_q[p][i]) if ((model_q[p][i] & cm) != 0) emem = 1;
    acc  = !eb && !ef && !emem;
    ea   = model_q[p].size();
    elat = (eb || ef) ? 2 : ((acc && ea == 0) ? 3 : -1);
    base = wr_total;
    @(negedge clk);
    jogador = 1'(p); tipo = 3'(t); direcao = d[0]; orientacao = 2'(o);
    x1 = 4'(x); y1 = 4'(y); novo_jogo = ng; enable = 1'b1;
    n = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      n++;
      if (ready === 1'b1) got = 1;
      else begin
        novo_jogo = 1'b0;
        jogador = 1'($urandom); tipo = 3'($urandom); direcao = 1'($urandom);
        orientacao = 2'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
      end
    end
    chk({name, ".ready"}, 64'(got), 64'd1);
    chk({name, ".borda"}, 64'(c_borda), 64'(eb));
    chk({name, ".cheio"}, 64'(c_cheio), 64'(ef));
    chk({name, ".memoria"}, 64'(c_mem), 64'(emem));
    chk({name, ".conflito"}, 64'(conflito), 64'(!acc));
    chk({name, ".writes"}, 64'(wr_total - base), 64'(acc ? 1 : 0));
    if (acc) begin
      chk({name, ".addr"}, 64'(wr_addr_seen), 64'(ea));
      chk({name, ".vetor"}, wr_vec_seen, em);
      chk({name, ".wr_jogador"}, 64'(wr_pl_seen), 64'(p));
      model_q[p].push_back(em);
    end
    if (elat > 0) chk({name, ".latency"}, 64'(n), 64'(elat));
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    chk({name, ".release"}, {62'd0, ready, conflito}, 64'd0);
    $display("[TB] %s p=%0d t=%0d d=%0d o=%0d (%0d,%0d) ng=%0b -> borda=%0b mem=%0b cheio=%0b wrote=%0b lat=%0d",
             name, p, t, d, o, x, y, ng, c_borda_prev(eb), emem, ef, acc, n);
  endtask

  function automatic bit c_borda_prev(input bit b);
    return b;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; novo_jogo = 1'b0; enable = 1'b0; jogador = '0; tipo = '0;
    direcao = 1'b0; orientacao = '0; x1 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {59'd0, ready, conflito, c_borda, c_mem, c_cheio}, 64'd0);
    chk("reset.wr_en", 64'(wr_en), 64'd0);
    chk("reset.addr", 64'(addr), 64'd0);
    chk("reset.vetor", vetor, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_req(0, 0, 0, 0, 3, 2, 0, "sub_3_2");
    do_req(0, 1, 0, 0, 3, 2, 1, "cruz_3_2_newgame");
    do_req(0, 0, 0, 0, 4, 2, 0, "sub_overlap");
    do_req(0, 4, 0, 0, 5, 0, 0, "porta_border");
    do_req(0, 4, 0, 0, 3, 0, 0, "porta_fit");
    do_req(0, 2, 0, 2, 0, 0, 0, "hidro_o2");
    do_req(0, 5, 0, 0, 1, 5, 0, "tipo_invalid");
    do_req(0, 2, 0, 0, 6, 6, 0, "hidro_edge");
    do_req(0, 0, 0, 0, 4, 3, 0, "sub_adjacent");
    for (int i = 0; i < 12; i++)
      do_req(1, 0, 0, 0, (i % 4) * 2, (i / 4) * 2, 0, "p1_fill");
    do_req(0, 0, 1, 0, 6, 5, 0, "p0_after_p1");

    // Reset while scanning player 0's stored ships.
    base = wr_total;
    @(negedge clk);
    jogador = 1'b0; tipo = 3'd0; direcao = 1'b0; x1 = 4'd7; y1 = 4'd7; enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_scan.writes", 64'(wr_total - base), 64'd0);
    chk("rst_scan.ready", 64'(ready), 64'd0);
    $display("[TB] rst_scan p=0 aborted, writes=%0d", wr_total - base);
    model_q[0].delete(); model_q[1].delete();
    do_req(1, 0, 0, 0, 0, 0, 0, "p1_after_rst");
    do_req(0, 3, 1, 0, 2, 2, 0, "p0_after_rst");

    for (int r = 0; r < 80; r++) begin
      int t, xm;
      t  = $urandom_range(0, 9);
      if (t > 7) t = $urandom_range(0, 4);
      xm = ($urandom_range(0, 7) == 0) ? 15 : 9;
      do_req($urandom_range(0, 1), t, $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, xm), $urandom_range(0, xm),
             ($urandom_range(0, 24) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
